// File: rtl/joystick_adc_reader.sv
// Reads an MCP3002-style 2-channel SAR ADC continuously and publishes the top
// nibble of X (ch0) and Y (ch1). Both nibbles update together once per ch0/ch1 pair.
module joystick_adc_reader #(
    parameter int CLK_DIV    = 32,
    parameter int ADC_BITS   = 10,
    parameter int IDLE_TICKS = 2
) (
    input  logic       fastClock,
    input  logic       reset,
    input  logic       enable,
    input  logic       adcDout,
    output logic       adcCsN,
    output logic       adcSclk,
    output logic       adcDin,
    output logic [3:0] xOut,
    output logic [3:0] yOut,
    output logic       sampleValid
);
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int IDLE_W = $clog2(IDLE_TICKS + 1);
    localparam int BIT_W  = $clog2(ADC_BITS + 1);
    localparam logic [3:0] CENTRE = 4'b1000;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_NULL, S_DATA} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [ADC_BITS-1:0] shift_q, shift_d;
    logic [3:0]          xhold_q, xhold_d, x_q, x_d, y_q, y_d;
    logic                ch_q, ch_d;
    logic                sclk_q, sclk_d;
    logic                csn_q, csn_d;
    logic                din_q, din_d;
    logic                valid_q, valid_d;
    logic                tick;

    assign tick = (div_q == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge fastClock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            idle_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            xhold_q <= CENTRE;
            x_q     <= CENTRE;
            y_q     <= CENTRE;
            ch_q    <= 1'b0;
            sclk_q  <= 1'b0;
            csn_q   <= 1'b1;
            din_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idle_q  <= idle_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            xhold_q <= xhold_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ch_q    <= ch_d;
            sclk_q  <= sclk_d;
            csn_q   <= csn_d;
            din_q   <= din_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + 1'b1;
        idle_d  = idle_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        xhold_d = xhold_q;
        x_d     = x_q;
        y_d     = y_q;
        ch_d    = ch_q;
        sclk_d  = sclk_q;
        csn_d   = csn_q;
        din_d   = din_q;
        valid_d = 1'b0;
        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (idle_q != IDLE_W'(IDLE_TICKS)) idle_d = idle_q + 1'b1;
                    if (enable && idle_q == IDLE_W'(IDLE_TICKS)) begin
                        csn_d   = 1'b0;
                        din_d   = 1'b1;
                        bit_d   = '0;
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    sclk_d = ~sclk_q;
                    // bit_q counts rising edges so far; each falling edge presents the next command bit
                    if (!sclk_q) begin
                        bit_d = bit_q + 1'b1;
                    end else if (bit_q == BIT_W'(4)) begin
                        din_d   = 1'b0;
                        state_d = S_NULL;
                    end else begin
                        din_d = (bit_q == BIT_W'(2)) ? ch_q : 1'b1;
                    end
                end
                S_NULL: begin
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        bit_d   = '0;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_q == BIT_W'(ADC_BITS)) begin
                        sclk_d  = 1'b0;
                        csn_d   = 1'b1;
                        din_d   = 1'b0;
                        // the frame-end tick already counts as the first chip-select-high tick
                        idle_d  = IDLE_W'(1);
                        state_d = S_IDLE;
                        ch_d    = ~ch_q;
                        if (!ch_q) begin
                            xhold_d = shift_q[ADC_BITS-1 -: 4];
                        end else begin
                            x_d     = xhold_q;
                            y_d     = shift_q[ADC_BITS-1 -: 4];
                            valid_d = 1'b1;
                        end
                    end else begin
                        sclk_d = ~sclk_q;
                        if (!sclk_q) begin
                            shift_d = {shift_q[ADC_BITS-2:0], adcDout};
                            bit_d   = bit_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        adcCsN      = csn_q;
        adcSclk     = sclk_q;
        adcDin      = din_q;
        xOut        = x_q;
        yOut        = y_q;
        sampleValid = valid_q;
    end
endmodule

// File: tb/tb_joystick_adc_reader.sv
// Bench for joystick_adc_reader: a behavioural MCP3002 model answers each frame,
// and expected nibbles/timings come from the frame arithmetic of the ADC protocol.
module tb_joystick_adc_reader;
    localparam int CD = 32, NB = 10, IT = 2;
    localparam int FRAME_TICKS = 2 * (5 + NB);
    localparam int PAIR = 2 * (FRAME_TICKS + IT) * CD;
    localparam int PAIR_S = 2 * (2 * (5 + 8) + 2) * 2;

    logic clk = 1'b0, rst = 1'b0;
    logic [1:0] en, cs, sclk, din, dout, sv;
    logic [1:0][3:0] xo, yo;
    int checks = 0, failures = 0, cyc = 0, t_last = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    joystick_adc_reader u_dut (
        .fastClock(clk), .reset(rst), .enable(en[0]), .adcDout(dout[0]),
        .adcCsN(cs[0]), .adcSclk(sclk[0]), .adcDin(din[0]),
        .xOut(xo[0]), .yOut(yo[0]), .sampleValid(sv[0]));

    joystick_adc_reader #(.CLK_DIV(2), .ADC_BITS(8), .IDLE_TICKS(2)) u_small (
        .fastClock(clk), .reset(rst), .enable(en[1]), .adcDout(dout[1]),
        .adcCsN(cs[1]), .adcSclk(sclk[1]), .adcDin(din[1]),
        .xOut(xo[1]), .yOut(yo[1]), .sampleValid(sv[1]));

    // ADC model: per-device words per channel, frame log of command bits and CS-low length
    logic [9:0] wd [2][2];
    logic [3:0] cmd [2], last_cmd [2];
    logic       cs_prev [2], sclk_prev [2];
    int         rises [2], cslen [2], last_len [2], frames [2];

    always @(negedge clk) begin : adc_model
        int nb;
        int nxt;
        for (int d = 0; d < 2; d++) begin
            nb = (d == 0) ? NB : 8;
            if (cs[d] === 1'b1) begin
                if (cs_prev[d] === 1'b0) begin
                    last_cmd[d] = cmd[d];
                    last_len[d] = cslen[d];
                    frames[d]++;
                end
                rises[d] = 0;
                cslen[d] = 0;
                cmd[d]   = 4'b0;
            end else begin
                cslen[d]++;
                if (sclk[d] === 1'b1 && sclk_prev[d] === 1'b0) begin
                    rises[d]++;
                    if (rises[d] <= 4) cmd[d] = {cmd[d][2:0], din[d]};
                end
            end
            cs_prev[d]   = cs[d];
            sclk_prev[d] = sclk[d];
            nxt = rises[d] + 1;
            dout[d] = (cs[d] === 1'b0 && nxt >= 6 && nxt < 6 + nb) ?
                      wd[d][cmd[d][1]][nb - 1 - (nxt - 6)] : 1'b0;
        end
    end

    task automatic wait_frames(input int d, input int budget, output bit ok);
        int f0 = frames[d];
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (frames[d] != f0) begin ok = 1'b1; return; end
        end
    endtask

    task automatic wait_sv(input int d, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (sv[d] === 1'b1) begin ok = 1'b1; return; end
        end
    endtask

    task automatic wait_cs_low(input int d, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (cs[d] === 1'b0) begin ok = 1'b1; return; end
        end
    endtask

    task automatic test_reset;
        en = 2'b11;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (cs !== 2'b11) begin failures++; $display("FAIL reset_cs got=%b exp=11", cs); end
        checks++; if (sclk !== 2'b00) begin failures++; $display("FAIL reset_sclk got=%b exp=00", sclk); end
        checks++; if (din !== 2'b00) begin failures++; $display("FAIL reset_din got=%b exp=00", din); end
        checks++; if (sv !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", sv); end
        checks++; if (xo !== 8'h88) begin failures++; $display("FAIL reset_x got=%h exp=88", xo); end
        checks++; if (yo !== 8'h88) begin failures++; $display("FAIL reset_y got=%h exp=88", yo); end
    endtask

    task automatic test_first_frame;
        int n = 0;
        bit ok;
        wd[0][0] = 10'h2A5; wd[0][1] = 10'h0FF;
        @(negedge clk);
        rst = 1'b0;
        while (cs[0] !== 1'b0 && n < 1000) begin @(negedge clk); #1; n++; end
        checks++; if (n != (IT + 1) * CD) begin failures++; $display("FAIL first_cs_fall got=%0d exp=%0d", n, (IT + 1) * CD); end
        wait_frames(0, 2000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL frame1_timeout got=0 exp=1"); end
        checks++; if (last_len[0] != FRAME_TICKS * CD) begin failures++; $display("FAIL cs_low_len got=%0d exp=%0d", last_len[0], FRAME_TICKS * CD); end
        checks++; if (last_cmd[0] !== 4'b1101) begin failures++; $display("FAIL frame1_cmd got=%b exp=1101", last_cmd[0]); end
        checks++; if (xo[0] !== 4'h8 || sv[0] !== 1'b0) begin failures++; $display("FAIL after_frame1 got x=%h v=%b exp x=8 v=0", xo[0], sv[0]); end
        wait_sv(0, PAIR, ok);
        t_last = cyc;
        checks++; if (!ok) begin failures++; $display("FAIL pair1_timeout got=0 exp=1"); end
        checks++; if (last_cmd[0] !== 4'b1111) begin failures++; $display("FAIL frame2_cmd got=%b exp=1111", last_cmd[0]); end
        checks++; if (xo[0] !== 4'hA || yo[0] !== 4'h3) begin failures++; $display("FAIL pair1_xy got=%h%h exp=a3", xo[0], yo[0]); end
        @(negedge clk); #1;
        checks++; if (sv[0] !== 1'b0) begin failures++; $display("FAIL valid_width got=%b exp=0", sv[0]); end
    endtask

    task automatic test_values;
        logic [9:0] w0, w1;
        bit ok;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin w0 = 10'h3FF; w1 = 10'h000; end
            else if (k == 1) begin w0 = 10'h1C0; w1 = 10'h200; end
            else begin w0 = 10'($urandom_range(0, 1023)); w1 = 10'($urandom_range(0, 1023)); end
            wd[0][0] = w0; wd[0][1] = w1;
            wait_sv(0, PAIR + 100, ok);
            checks++; if (!ok) begin failures++; $display("FAIL pair_timeout k=%0d", k); end
            checks++; if (cyc - t_last != PAIR) begin failures++; $display("FAIL pair_spacing k=%0d got=%0d exp=%0d", k, cyc - t_last, PAIR); end
            checks++; if (xo[0] !== 4'(w0 >> (NB - 4)) || yo[0] !== 4'(w1 >> (NB - 4))) begin
                failures++; $display("FAIL pair_xy k=%0d got=%h%h exp=%h%h", k, xo[0], yo[0], 4'(w0 >> (NB - 4)), 4'(w1 >> (NB - 4)));
            end
            t_last = cyc;
        end
    endtask

    task automatic test_enable;
        logic [9:0] e0, e1;
        logic [3:0] xprev, yprev;
        int lows = 0, pulses = 0;
        bit ok;
        e0 = 10'($urandom_range(0, 511));
        e1 = 10'($urandom_range(576, 1023));
        wd[0][0] = e0; wd[0][1] = e1;
        xprev = xo[0]; yprev = yo[0];
        wait_cs_low(0, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL en_start_timeout got=0 exp=1"); end
        repeat (15 * CD) @(negedge clk);
        #1 en[0] = 1'b0;
        wait_frames(0, 2000, ok);
        checks++; if (!ok || last_cmd[0] !== 4'b1101) begin failures++; $display("FAIL en_frame_done got ok=%0d cmd=%b exp 1 1101", ok, last_cmd[0]); end
        for (int i = 0; i < 2 * PAIR; i++) begin
            @(negedge clk); #1;
            if (cs[0] !== 1'b1) lows++;
            if (sv[0] !== 1'b0) pulses++;
        end
        checks++; if (lows != 0 || pulses != 0) begin failures++; $display("FAIL disabled_quiet got lows=%0d pulses=%0d exp 0 0", lows, pulses); end
        checks++; if (xo[0] !== xprev || yo[0] !== yprev) begin failures++; $display("FAIL disabled_hold got=%h%h exp=%h%h", xo[0], yo[0], xprev, yprev); end
        en[0] = 1'b1;
        wait_sv(0, PAIR, ok);
        checks++; if (!ok) begin failures++; $display("FAIL reenable_timeout got=0 exp=1"); end
        checks++; if (last_cmd[0] !== 4'b1111) begin failures++; $display("FAIL reenable_cmd got=%b exp=1111", last_cmd[0]); end
        checks++; if (xo[0] !== 4'(e0 >> 6) || yo[0] !== 4'(e1 >> 6)) begin
            failures++; $display("FAIL reenable_xy got=%h%h exp=%h%h", xo[0], yo[0], 4'(e0 >> 6), 4'(e1 >> 6));
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] r0, r1;
        bit ok;
        wait_cs_low(0, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rstmid_start_timeout got=0 exp=1"); end
        repeat (16 * CD) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (cs[0] !== 1'b1 || sclk[0] !== 1'b0) begin failures++; $display("FAIL rstmid_pins got cs=%b sclk=%b exp 1 0", cs[0], sclk[0]); end
        checks++; if (xo[0] !== 4'h8 || yo[0] !== 4'h8) begin failures++; $display("FAIL rstmid_xy got=%h%h exp=88", xo[0], yo[0]); end
        r0 = 10'($urandom_range(0, 1023)); r1 = 10'($urandom_range(0, 1023));
        wd[0][0] = r0; wd[0][1] = r1;
        @(negedge clk);
        #1 rst = 1'b0;
        wait_frames(0, 2000, ok);
        checks++; if (!ok || last_cmd[0] !== 4'b1101) begin failures++; $display("FAIL rstmid_first_ch got ok=%0d cmd=%b exp 1 1101", ok, last_cmd[0]); end
        wait_sv(0, PAIR, ok);
        checks++; if (!ok || xo[0] !== 4'(r0 >> 6) || yo[0] !== 4'(r1 >> 6)) begin
            failures++; $display("FAIL rstmid_pair got ok=%0d xy=%h%h exp=%h%h", ok, xo[0], yo[0], 4'(r0 >> 6), 4'(r1 >> 6));
        end
    endtask

    task automatic test_small;
        logic [9:0] w0, w1;
        logic p;
        int r1 = -1, r2 = -1, ts = 0;
        bit ok;
        wait_frames(1, 500, ok);
        p = sclk[1];
        for (int i = 0; i < 200 && r2 < 0; i++) begin
            @(negedge clk); #1;
            if (cs[1] === 1'b0 && sclk[1] === 1'b1 && p === 1'b0) begin
                if (r1 < 0) r1 = cyc; else r2 = cyc;
            end
            p = sclk[1];
        end
        checks++; if (r2 - r1 != 4) begin failures++; $display("FAIL small_sclk_period got=%0d exp=4", r2 - r1); end
        wait_frames(1, 500, ok);
        checks++; if (!ok || last_len[1] != 52) begin failures++; $display("FAIL small_cs_len got=%0d exp=52", last_len[1]); end
        wait_sv(1, 500, ok);
        ts = cyc;
        for (int k = 0; k < 4; k++) begin
            w0 = 10'($urandom_range(0, 255)); w1 = 10'($urandom_range(0, 255));
            wd[1][0] = w0; wd[1][1] = w1;
            wait_sv(1, 500, ok);
            checks++; if (!ok || cyc - ts != PAIR_S) begin failures++; $display("FAIL small_spacing k=%0d got=%0d exp=%0d", k, cyc - ts, PAIR_S); end
            checks++; if (xo[1] !== 4'(w0 >> 4) || yo[1] !== 4'(w1 >> 4)) begin
                failures++; $display("FAIL small_xy k=%0d got=%h%h exp=%h%h", k, xo[1], yo[1], 4'(w0 >> 4), 4'(w1 >> 4));
            end
            ts = cyc;
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            cs_prev[d] = 1'b1; sclk_prev[d] = 1'b0; rises[d] = 0; cslen[d] = 0;
            frames[d] = 0; last_len[d] = 0; cmd[d] = 4'b0; last_cmd[d] = 4'b0;
            wd[d][0] = 10'h0; wd[d][1] = 10'h0;
        end
        en = 2'b00;
        test_reset;
        test_first_frame;
        test_values;
        test_enable;
        test_reset_mid;
        test_small;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
